// File: rtl/memory_arbiter.sv
// Two-requester (fetch / data) arbiter onto a single memory port, one transaction in flight, with watchdog abort.
// Define MEM_ARBITER_RR_EN for round-robin tie-breaking; default is fixed priority (data beats fetch).
module memory_arbiter #(
  parameter int unsigned WATCHDOG_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic [31:0] dm_addr,
  input  logic        dm_we,
  input  logic [1:0]  dm_mask,
  input  logic [31:0] dm_wdata,
  output logic        dm_gnt,
  output logic        dm_rvalid,
  output logic [31:0] dm_rdata,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [1:0]  mem_mask,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        timeout
);

  typedef enum logic [1:0] {MEM_BYTE, MEM_HALF, MEM_WORD} memory_mask_t;
  typedef enum logic [1:0] {IDLE, WAIT_ACCEPT, WAIT_RESP} state_e;
  typedef enum logic {OWN_IF, OWN_DM} owner_e;

  localparam int unsigned WD_W = $clog2(WATCHDOG_CYCLES + 1);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [31:0]       addr_q, addr_d;
  logic              we_q, we_d;
  logic [1:0]        mask_q, mask_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;
  logic              expire;
  logic              pick_dm;
  logic              resp_valid;
  logic [31:0]       resp_data;
`ifdef MEM_ARBITER_RR_EN
  owner_e            last_q, last_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= OWN_IF;
      addr_q  <= '0;
      we_q    <= 1'b0;
      mask_q  <= '0;
      wdata_q <= '0;
      wdog_q  <= '0;
`ifdef MEM_ARBITER_RR_EN
      last_q  <= OWN_IF;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      mask_q  <= mask_d;
      wdata_q <= wdata_d;
      wdog_q  <= wdog_d;
`ifdef MEM_ARBITER_RR_EN
      last_q  <= last_d;
`endif
    end
  end

  assign expire = (wdog_q == WD_W'(WATCHDOG_CYCLES));

  always_comb begin
`ifdef MEM_ARBITER_RR_EN
    pick_dm = dm_req && (!if_req || (last_q == OWN_IF));
`else
    pick_dm = dm_req;
`endif
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    we_d       = we_q;
    mask_d     = mask_q;
    wdata_d    = wdata_q;
    wdog_d     = wdog_q;
`ifdef MEM_ARBITER_RR_EN
    last_d     = last_q;
`endif
    if_gnt     = 1'b0;
    dm_gnt     = 1'b0;
    mem_req    = 1'b0;
    timeout    = 1'b0;
    resp_valid = 1'b0;
    resp_data  = '0;
    unique case (state_q)
      IDLE: begin
        // gnt is combinational, so it must also be masked while reset is held
        if (rst_n && (if_req || dm_req)) begin
          if (pick_dm) begin
            dm_gnt  = 1'b1;
            owner_d = OWN_DM;
            addr_d  = dm_addr;
            we_d    = dm_we;
            mask_d  = dm_mask;
            wdata_d = dm_wdata;
          end else begin
            if_gnt  = 1'b1;
            owner_d = OWN_IF;
            addr_d  = if_addr;
            we_d    = 1'b0;
            mask_d  = MEM_WORD;
            wdata_d = '0;
          end
`ifdef MEM_ARBITER_RR_EN
          last_d  = owner_d;
`endif
          wdog_d  = '0;
          state_d = WAIT_ACCEPT;
        end
      end
      WAIT_ACCEPT: begin
        if (expire) begin
          timeout    = 1'b1;
          resp_valid = 1'b1;
          state_d    = IDLE;
        end else begin
          mem_req = 1'b1;
          wdog_d  = wdog_q + WD_W'(1);
          if (mem_ready) state_d = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        if (mem_rvalid) begin
          resp_valid = 1'b1;
          resp_data  = mem_rdata;
          state_d    = IDLE;
        end else if (expire) begin
          timeout    = 1'b1;
          resp_valid = 1'b1;
          state_d    = IDLE;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign if_rvalid = resp_valid && (owner_q == OWN_IF);
  assign dm_rvalid = resp_valid && (owner_q == OWN_DM);
  assign if_rdata  = if_rvalid ? resp_data : '0;
  assign dm_rdata  = dm_rvalid ? resp_data : '0;

  assign mem_addr  = addr_q;
  assign mem_we    = we_q;
  assign mem_mask  = mask_q;
  assign mem_wdata = wdata_q;

endmodule
